// File: rtl/elevator_pkg.sv
// Shared defaults and types for the elevator request scheduler.
package elevator_pkg;

  localparam int unsigned DEF_NUM_FLOORS  = 10;
  localparam int unsigned DEF_FLOOR_W     = 4;
  localparam int unsigned DEF_DWELL_COUNT = 32'd5000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DWELL = 2'd2
  } sched_state_t;

  typedef logic [DEF_FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/elevator_next_floor.sv
// Combinational SCAN helper: nearest pending floor above and below the cabin.
module elevator_next_floor
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] i_pending,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  output logic [FLOOR_W-1:0]    o_above_c,
  output logic                  o_has_above_c,
  output logic [FLOOR_W-1:0]    o_below_c,
  output logic                  o_has_below_c
);

  // Downward scan leaves the lowest match above; upward scan leaves the highest below.
  always_comb begin
    o_above_c     = '0;
    o_has_above_c = 1'b0;
    o_below_c     = '0;
    o_has_below_c = 1'b0;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (i_pending[i] && (FLOOR_W'(i) > i_current_floor)) begin
        o_above_c     = FLOOR_W'(i);
        o_has_above_c = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (i_pending[i] && (FLOOR_W'(i) < i_current_floor)) begin
        o_below_c     = FLOOR_W'(i);
        o_has_below_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN-order floor-call scheduler with door dwell, feeding the elevator FSM.
// Optional macro SCHED_INPUT_SYNC_EN: synchronize call_valid and edge-detect it.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W     = DEF_FLOOR_W,
  parameter int unsigned DWELL_COUNT = DEF_DWELL_COUNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up,
  output logic                  call_err
);

  localparam int unsigned CNT_W      = 32;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_COUNT - 1);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = NUM_FLOORS'(1);

  logic                  w_call_valid;
  logic [FLOOR_W-1:0]    w_call_floor;

`ifdef SCHED_INPUT_SYNC_EN
  logic [2:0]         r_vld_sync;
  logic               r_vld_q;
  logic [FLOOR_W-1:0] r_flr_s1;
  logic [FLOOR_W-1:0] r_flr_s2;
  logic [FLOOR_W-1:0] r_flr_q;

  // Two-flop synchronizer, rising-edge detect, floor delayed to stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_sync <= '0;
      r_vld_q    <= 1'b0;
      r_flr_s1   <= '0;
      r_flr_s2   <= '0;
      r_flr_q    <= '0;
    end else begin
      r_vld_sync <= {r_vld_sync[1:0], call_valid};
      r_vld_q    <= r_vld_sync[1] & ~r_vld_sync[2];
      r_flr_s1   <= call_floor;
      r_flr_s2   <= r_flr_s1;
      r_flr_q    <= r_flr_s2;
    end
  end

  assign w_call_valid = r_vld_q;
  assign w_call_floor = r_flr_q;
`else
  assign w_call_valid = call_valid;
  assign w_call_floor = call_floor;
`endif

  sched_state_t          r_state;
  sched_state_t          w_state_nxt;
  logic [FLOOR_W-1:0]    r_req;
  logic [FLOOR_W-1:0]    w_req_nxt;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] w_set_mask;
  logic [NUM_FLOORS-1:0] w_clr_mask;
  logic [NUM_FLOORS-1:0] w_cur_mask;
  logic                  r_dir_up;
  logic                  w_dir_nxt;
  logic                  r_door;
  logic                  w_door_nxt;
  logic                  r_call_err;
  logic [CNT_W-1:0]      r_dwell_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  logic                  w_call_in_range;
  logic                  w_cap;
  logic                  w_cur_in_range;
  logic                  w_cur_pend;
  logic [FLOOR_W-1:0]    w_cur_safe;
  logic [FLOOR_W-1:0]    w_above;
  logic [FLOOR_W-1:0]    w_below;
  logic                  w_has_above;
  logic                  w_has_below;

  assign w_call_in_range = (32'(w_call_floor) < NUM_FLOORS);
  assign w_cap           = w_call_valid && w_call_in_range;
  assign w_cur_in_range  = (32'(current_floor) < NUM_FLOORS);
  assign w_cur_mask      = w_cur_in_range ? (ONE_HOT0 << current_floor) : '0;
  assign w_cur_pend      = |(r_pending & w_cur_mask);
  // A cabin reporting an out-of-range floor must not leak into requested_floor.
  assign w_cur_safe      = w_cur_in_range ? current_floor : FLOOR_W'(NUM_FLOORS - 1);

  elevator_next_floor #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_next_floor (
    .i_pending       (r_pending),
    .i_current_floor (current_floor),
    .o_above_c       (w_above),
    .o_has_above_c   (w_has_above),
    .o_below_c       (w_below),
    .o_has_below_c   (w_has_below)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_pending   <= '0;
      r_dir_up    <= 1'b0;
      r_door      <= 1'b0;
      r_call_err  <= 1'b0;
      r_dwell_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_pending   <= (r_pending | w_set_mask) & ~w_clr_mask;
      r_dir_up    <= w_dir_nxt;
      r_door      <= w_door_nxt;
      r_call_err  <= w_call_valid && !w_call_in_range;
      r_dwell_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_dir_nxt   = r_dir_up;
    w_cnt_nxt   = r_dwell_cnt;
    w_clr_mask  = '0;
    w_set_mask  = w_cap ? (ONE_HOT0 << w_call_floor) : '0;

    unique case (r_state)
      IDLE: begin
        // Leaving IDLE loads the target directly so a call lands in two cycles.
        w_req_nxt = w_cur_safe;
        if (w_cur_pend) begin
          w_clr_mask  = w_cur_mask;
          w_cnt_nxt   = '0;
          w_state_nxt = DWELL;
        end else if (w_has_above) begin
          w_dir_nxt   = 1'b1;
          w_req_nxt   = w_above;
          w_state_nxt = MOVE;
        end else if (w_has_below) begin
          w_dir_nxt   = 1'b0;
          w_req_nxt   = w_below;
          w_state_nxt = MOVE;
        end
      end

      MOVE: begin
        if (w_cur_pend && (current_floor == r_req)) begin
          w_clr_mask  = w_cur_mask;
          w_req_nxt   = current_floor;
          w_cnt_nxt   = '0;
          w_state_nxt = DWELL;
        end else if (r_dir_up ? w_has_above : w_has_below) begin
          w_req_nxt = r_dir_up ? w_above : w_below;
        end else if (r_dir_up ? w_has_below : w_has_above) begin
          w_dir_nxt = ~r_dir_up;
          w_req_nxt = r_dir_up ? w_below : w_above;
        end else begin
          // Only the current floor (or nothing) is left.
          w_req_nxt = w_cur_safe;
          if (!w_cur_pend) begin
            w_state_nxt = IDLE;
          end
        end
      end

      DWELL: begin
        if (w_cap && (w_call_floor == current_floor)) begin
          w_set_mask = '0;
          w_cnt_nxt  = '0;
        end else if (r_dwell_cnt == DWELL_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (|r_pending) ? MOVE : IDLE;
          w_dir_nxt   = r_dir_up ? w_has_above : (w_has_above && !w_has_below);
        end else begin
          w_cnt_nxt = r_dwell_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_door_nxt = (w_state_nxt == DWELL);
  end

  assign requested_floor = r_req;
  assign pending         = r_pending;
  assign door_open       = r_door;
  assign dir_up          = r_dir_up;
  assign call_err        = r_call_err;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler (default build, short dwell).
module tb_elevator_request_scheduler;

  localparam int unsigned NF = 10;
  localparam int unsigned FW = 4;
  localparam int unsigned DW = 4;

  localparam int S_REQ  = 0;
  localparam int S_PEND = 1;
  localparam int S_DOOR = 2;
  localparam int S_DIR  = 3;
  localparam int S_ERR  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          call_valid = 1'b0;
  logic [FW-1:0] call_floor = '0;
  logic [FW-1:0] current_floor = '0;
  logic [FW-1:0] requested_floor;
  logic [NF-1:0] pending;
  logic          door_open;
  logic          dir_up;
  logic          call_err;

  elevator_request_scheduler #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (FW),
    .DWELL_COUNT (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .call_valid      (call_valid),
    .call_floor      (call_floor),
    .current_floor   (current_floor),
    .requested_floor (requested_floor),
    .pending         (pending),
    .door_open       (door_open),
    .dir_up          (dir_up),
    .call_err        (call_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          sel;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] act;

  function automatic logic [15:0] sample(int sel);
    case (sel)
      S_REQ:   return 16'(requested_floor);
      S_PEND:  return 16'(pending);
      S_DOOR:  return 16'(door_open);
      S_DIR:   return 16'(dir_up);
      default: return 16'(call_err);
    endcase
  endfunction

  // Monitor: compares every expectation due after the most recent rising edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        act = sample(sb[i].sel);
        n_checks++;
        if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(int f);
    call_valid = 1'b1;
    call_floor = FW'(f);
    tick(1);
    call_valid = 1'b0;
  endtask

  task automatic chk(int at, int sel, int v, string nm);
    sb.push_back('{at, sel, 16'(v), nm});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  int t0;

  initial begin
    // Reset values
    rst_n = 1'b0;
    tick(3);
    n_checks++;
    if (requested_floor !== FW'(0)) begin
      n_fail++;
      $display("FAIL direct_rst_req got=0x%0h want=0x0", requested_floor);
    end
    n_checks++;
    if (pending !== NF'(0)) begin
      n_fail++;
      $display("FAIL direct_rst_pend got=0x%0h want=0x0", pending);
    end
    n_checks++;
    if (door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_rst_door got=0x%0h want=0x0", door_open);
    end
    n_checks++;
    if (dir_up !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_rst_dir got=0x%0h want=0x0", dir_up);
    end
    n_checks++;
    if (call_err !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_rst_err got=0x%0h want=0x0", call_err);
    end
    chk(cyc, S_REQ, 0, "rst_req");
    chk(cyc, S_PEND, 0, "rst_pend");
    chk(cyc, S_DOOR, 0, "rst_door");
    chk(cyc, S_DIR, 0, "rst_dir");
    chk(cyc, S_ERR, 0, "rst_err");
    rst_n = 1'b1;
    tick(1);

    // 1: single call from idle, dwell exactly DW cycles
    t0 = cyc;
    chk(t0 + 1, S_PEND, 'h008, "t1_pend_set");
    chk(t0 + 2, S_REQ, 3, "t1_req_lat2");
    chk(t0 + 2, S_DIR, 1, "t1_dir_up");
    chk(t0 + 3, S_DOOR, 0, "t1_door_closed_moving");
    for (int k = 4; k <= 7; k++) chk(t0 + k, S_DOOR, 1, "t1_door_open");
    chk(t0 + 4, S_PEND, 0, "t1_pend_clr");
    chk(t0 + 8, S_DOOR, 0, "t1_door_end");
    chk(t0 + 8, S_DIR, 0, "t1_dir_idle");
    chk(t0 + 9, S_REQ, 3, "t1_req_idle");
    strobe(3);
    tick(2);
    current_floor = FW'(3);
    tick(7);

    // 2: en-route pickup then sweep reversal
    t0 = cyc;
    chk(t0 + 1, S_PEND, 'h080, "t2_pend7");
    chk(t0 + 2, S_REQ, 7, "t2_req7");
    chk(t0 + 2, S_DIR, 1, "t2_dir_up");
    chk(t0 + 3, S_PEND, 'h0A0, "t2_pend57");
    chk(t0 + 3, S_REQ, 7, "t2_req7_hold");
    chk(t0 + 4, S_PEND, 'h0A2, "t2_pend157");
    chk(t0 + 4, S_REQ, 5, "t2_retarget5");
    chk(t0 + 5, S_PEND, 'h082, "t2_served5");
    chk(t0 + 5, S_DOOR, 1, "t2_door5");
    chk(t0 + 8, S_DOOR, 1, "t2_door5_last");
    chk(t0 + 9, S_DOOR, 0, "t2_door5_end");
    chk(t0 + 9, S_DIR, 1, "t2_dir_kept");
    chk(t0 + 10, S_REQ, 7, "t2_req7_again");
    chk(t0 + 11, S_PEND, 'h002, "t2_served7");
    chk(t0 + 11, S_DOOR, 1, "t2_door7");
    chk(t0 + 15, S_DIR, 0, "t2_dir_flip");
    chk(t0 + 15, S_DOOR, 0, "t2_door7_end");
    chk(t0 + 16, S_REQ, 1, "t2_req1");
    chk(t0 + 17, S_PEND, 0, "t2_served1");
    chk(t0 + 17, S_DOOR, 1, "t2_door1");
    chk(t0 + 21, S_DOOR, 0, "t2_door1_end");
    chk(t0 + 21, S_DIR, 0, "t2_dir_idle");
    current_floor = FW'(2);
    strobe(7);
    tick(1);
    strobe(5);
    strobe(1);
    current_floor = FW'(5);
    tick(6);
    current_floor = FW'(7);
    tick(6);
    current_floor = FW'(1);
    tick(6);

    // 3: call for current floor during dwell restarts the counter
    t0 = cyc;
    chk(t0 + 1, S_PEND, 'h010, "t3_pend4");
    chk(t0 + 2, S_DOOR, 1, "t3_door");
    chk(t0 + 2, S_PEND, 0, "t3_pend_clr");
    chk(t0 + 5, S_PEND, 0, "t3_not_latched");
    chk(t0 + 6, S_DOOR, 1, "t3_door_restart");
    chk(t0 + 8, S_DOOR, 1, "t3_door_last");
    chk(t0 + 9, S_DOOR, 0, "t3_door_end");
    current_floor = FW'(4);
    strobe(4);
    tick(3);
    strobe(4);
    tick(5);

    // 4: out-of-range calls, then 5: reset mid-MOVE
    t0 = cyc;
    chk(t0 + 1, S_ERR, 1, "t4_err12");
    chk(t0 + 1, S_PEND, 0, "t4_pend_kept");
    chk(t0 + 2, S_ERR, 0, "t4_err_pulse");
    chk(t0 + 2, S_PEND, 'h200, "t4_pend9");
    chk(t0 + 3, S_ERR, 1, "t4_err10");
    chk(t0 + 3, S_PEND, 'h200, "t4_pend_kept10");
    chk(t0 + 4, S_ERR, 0, "t4_err_clear");
    chk(t0 + 6, S_PEND, 'h2A4, "t5_pend_pre");
    chk(t0 + 6, S_REQ, 5, "t5_req_pre");
    chk(t0 + 6, S_DIR, 1, "t5_dir_pre");
    chk(t0 + 7, S_PEND, 0, "t5_rst_pend");
    chk(t0 + 7, S_REQ, 0, "t5_rst_req");
    chk(t0 + 7, S_DOOR, 0, "t5_rst_door");
    chk(t0 + 7, S_DIR, 0, "t5_rst_dir");
    chk(t0 + 7, S_ERR, 0, "t5_rst_err");
    chk(t0 + 8, S_PEND, 'h010, "t5_idle_capture");
    chk(t0 + 8, S_REQ, 4, "t5_idle_req");
    chk(t0 + 9, S_DOOR, 1, "t5_idle_dwell");
    strobe(12);
    strobe(9);
    strobe(10);
    strobe(2);
    strobe(5);
    strobe(7);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    strobe(4);
    tick(8);

    tick(2);
    foreach (sb[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s never_sampled got=none want=0x%0h", sb[i].name, sb[i].val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
